// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] PC_STEP           = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry shift FIFO; the head slot is always a register and reads EMPTY_ENTRY when empty.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter fetch_entry_t EMPTY_ENTRY = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t slot0_q, slot0_d;
  fetch_entry_t slot1_q, slot1_d;
  logic [1:0]   count_q, count_d;
  logic         do_pop_s;
  logic         do_push_s;

  // Next-state logic; a push into a full buffer without a pop is dropped.
  always_comb begin
    slot0_d   = slot0_q;
    slot1_d   = slot1_q;
    count_d   = count_q;
    do_pop_s  = pop_i && (count_q != 2'd0);
    do_push_s = push_i && ((count_q != 2'd2) || do_pop_s);
    if (flush_i) begin
      slot0_d = EMPTY_ENTRY;
      slot1_d = EMPTY_ENTRY;
      count_d = 2'd0;
    end else begin
      case ({do_push_s, do_pop_s})
        2'b10: begin
          if (count_q == 2'd0) begin
            slot0_d = push_data_i;
          end else begin
            slot1_d = push_data_i;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          slot0_d = (count_q == 2'd2) ? slot1_q : EMPTY_ENTRY;
          slot1_d = EMPTY_ENTRY;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            slot0_d = slot1_q;
            slot1_d = push_data_i;
          end else begin
            slot0_d = push_data_i;
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= EMPTY_ENTRY;
      slot1_q <= EMPTY_ENTRY;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;
  assign head_o  = slot0_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, keeps one memory request in flight and feeds decode
// through a two-entry buffer; redirects flush speculative state.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out
);

  localparam fetch_entry_t EMPTY_ENTRY = '{pc: 32'h0000_0000, instr: NOP_INSTR};

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic [31:0]  req_pc_q;
  logic         outstanding_q;

  logic         active_s;
  logic         pop_s;
  logic         push_s;
  logic         flush_s;
  logic         issue_s;
  logic [2:0]   level_s;
  logic [1:0]   buf_count_s;
  logic         buf_full_s;
  logic         buf_empty_s;
  fetch_entry_t buf_head_s;
  fetch_entry_t push_data_s;

  assign active_s    = (state_q != BOOT);
  assign pop_s       = instr_valid && id_ready && !redirect_valid;
  assign push_s      = (state_q == RUN) && imem_rvalid && !redirect_valid;
  assign flush_s     = active_s && redirect_valid;
  assign push_data_s = '{pc: req_pc_q, instr: imem_rdata};

  // Buffer occupancy after this edge, assuming the returning word is kept.
  assign level_s = {1'b0, buf_count_s} + {2'b00, imem_rvalid} - {2'b00, pop_s};
  assign issue_s = active_s && !redirect_valid && (!outstanding_q || imem_rvalid) &&
                   (level_s < 3'd2);

  // Control FSM, PC and in-flight request tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      req_pc_q      <= 32'h0000_0000;
      outstanding_q <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q <= RUN;
        end
        RUN, DRAIN: begin
          if (redirect_valid) begin
            pc_q          <= word_align(redirect_pc);
            outstanding_q <= outstanding_q && !imem_rvalid;
            state_q       <= (outstanding_q && !imem_rvalid) ? DRAIN : RUN;
          end else begin
            if (issue_s) begin
              req_pc_q      <= pc_q;
              pc_q          <= pc_q + PC_STEP;
              outstanding_q <= 1'b1;
            end else if (imem_rvalid) begin
              outstanding_q <= 1'b0;
            end
            // The stale word returning in DRAIN was dropped; normal fetch resumes.
            if ((state_q == DRAIN) && imem_rvalid) begin
              state_q <= RUN;
            end
          end
        end
        default: begin
          state_q <= BOOT;
        end
      endcase
    end
  end

  fetch_buffer #(
    .EMPTY_ENTRY(EMPTY_ENTRY)
  ) u_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push_s),
    .push_data_i(push_data_s),
    .pop_i      (pop_s),
    .flush_i    (flush_s),
    .full_o     (buf_full_s),
    .empty_o    (buf_empty_s),
    .count_o    (buf_count_s),
    .head_o     (buf_head_s)
  );

  assign imem_req    = issue_s;
  assign imem_addr   = pc_q;
  assign instr_valid = !buf_empty_s;
  assign instr_out   = buf_head_s.instr;
  assign pc_out      = buf_head_s.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-configurable memory model, request/response scoreboard,
// a cycle table for boot and stall, and hand-written redirect and reset sequences.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] XORK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, w_req;
  logic [31:0] imem_addr, w_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_ready = 1'b0;
  logic        instr_valid, w_valid;
  logic [31:0] instr_out, w_instr;
  logic [31:0] pc_out, w_pc;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
    .instr_valid(instr_valid), .instr_out(instr_out), .pc_out(pc_out)
  );

  // Second instance with a reset PC near the top of memory, run in lockstep with dut.
  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .NOP_INSTR(NOP_INSTR_DEFAULT)) dut_w (
    .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
    .instr_valid(w_valid), .instr_out(w_instr), .pc_out(w_pc)
  );

  typedef struct {
    logic        rdy;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        chk_w;
    logic [31:0] exp_wpc;
  } vec_t;

  vec_t         vt[13];
  fetch_entry_t exp_q[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           lat = 1;
  bit           pend_valid = 1'b0;
  int           pend_left = 0;
  logic [31:0]  pend_addr = 32'h0;
  logic [31:0]  exp_pc = 32'h0;
  logic         obs_req;
  logic [31:0]  obs_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_head();
    if (instr_valid) begin
      if (exp_q.size() == 0) begin
        check("stray_valid", 32'(instr_valid), 32'd0);
      end else begin
        check("sb_pc", pc_out, exp_q[0].pc);
        check("sb_instr", instr_out, exp_q[0].instr);
      end
    end else begin
      check("idle_instr", instr_out, NOP_INSTR_DEFAULT);
      check("idle_pc", pc_out, 32'h0);
    end
  endtask

  // One clock: check head, drive memory + controls, record any request, advance.
  task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
    chk_head();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (pend_valid) begin
      if (pend_left == 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = pend_addr ^ XORK;
        pend_valid  = 1'b0;
      end else begin
        pend_left--;
      end
    end
    id_ready       = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    #1;
    obs_req  = imem_req;
    obs_addr = imem_addr;
    if (instr_valid && rdy && !redir && exp_q.size() > 0) void'(exp_q.pop_front());
    if (redir) begin
      check("redir_noreq", 32'(imem_req), 32'd0);
      exp_q.delete();
      exp_pc = {rpc[31:2], 2'b00};
    end
    if (imem_req) begin
      check("one_outstanding", 32'(pend_valid), 32'd0);
      check("req_addr", imem_addr, exp_pc);
      pend_valid = 1'b1;
      pend_left  = lat;
      pend_addr  = imem_addr;
      exp_q.push_back('{pc: exp_pc, instr: exp_pc ^ XORK});
      exp_pc = exp_pc + 32'd4;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_vec(input int k, input logic rdy, input logic req, input logic [31:0] addr,
                         input logic valid, input logic [31:0] pc, input logic chkw,
                         input logic [31:0] wpc);
    vt[k] = '{rdy: rdy, exp_req: req, exp_addr: addr, exp_valid: valid, exp_pc: pc,
              chk_w: chkw, exp_wpc: wpc};
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got %0d expected 0 pending checks", 1);
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    bit got;

    // Boot, free-run, then a five-cycle decode stall starting with head PC 8.
    set_vec(0,  1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 32'h0);
    set_vec(1,  1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 1'b0, 32'h0);
    set_vec(2,  1'b1, 1'b1, 32'h04, 1'b0, 32'h00, 1'b0, 32'h0);
    set_vec(3,  1'b1, 1'b1, 32'h08, 1'b1, 32'h00, 1'b1, 32'hFFFF_FFF8);
    set_vec(4,  1'b1, 1'b1, 32'h0C, 1'b1, 32'h04, 1'b1, 32'hFFFF_FFFC);
    set_vec(5,  1'b0, 1'b0, 32'h10, 1'b1, 32'h08, 1'b1, 32'h0000_0000);
    set_vec(6,  1'b0, 1'b0, 32'h10, 1'b1, 32'h08, 1'b0, 32'h0);
    set_vec(7,  1'b0, 1'b0, 32'h10, 1'b1, 32'h08, 1'b0, 32'h0);
    set_vec(8,  1'b0, 1'b0, 32'h10, 1'b1, 32'h08, 1'b0, 32'h0);
    set_vec(9,  1'b0, 1'b0, 32'h10, 1'b1, 32'h08, 1'b0, 32'h0);
    set_vec(10, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08, 1'b0, 32'h0);
    set_vec(11, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C, 1'b0, 32'h0);
    set_vec(12, 1'b1, 1'b1, 32'h18, 1'b1, 32'h10, 1'b0, 32'h0);

    rst_n = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    exp_pc = RESET_PC_DEFAULT;
    repeat (2) @(negedge clk);
    check("reset_valid", 32'(instr_valid), 32'd0);
    check("reset_instr", instr_out, NOP_INSTR_DEFAULT);
    check("reset_addr", imem_addr, 32'h0);
    check("reset_req", 32'(imem_req), 32'd0);
    imem_rvalid = 1'b0;
    rst_n = 1'b1;

    for (int k = 0; k < 13; k++) begin
      check($sformatf("v%0d_valid", k), 32'(instr_valid), 32'(vt[k].exp_valid));
      check($sformatf("v%0d_pc", k), pc_out, vt[k].exp_pc);
      if (vt[k].chk_w) begin
        check($sformatf("v%0d_wrap_valid", k), 32'(w_valid), 32'd1);
        check($sformatf("v%0d_wrap_pc", k), w_pc, vt[k].exp_wpc);
      end
      step(vt[k].rdy, 1'b0, 32'h0);
      check($sformatf("v%0d_req", k), 32'(obs_req), 32'(vt[k].exp_req));
      check($sformatf("v%0d_addr", k), obs_addr, vt[k].exp_addr);
    end

    // Redirect in the same cycle as a returning word: word dropped, target fetched next.
    step(1'b1, 1'b1, 32'h0000_2000);
    check("rv_state", 32'(dut.state_q), 32'(RUN));
    step(1'b1, 1'b0, 32'h0);
    check("rv_req", 32'(obs_req), 32'd1);
    check("rv_addr", obs_addr, 32'h0000_2000);
    check("rv_valid_t2", 32'(instr_valid), 32'd0);
    step(1'b1, 1'b0, 32'h0);
    check("rv_valid_t3", 32'(instr_valid), 32'd1);
    check("rv_pc_t3", pc_out, 32'h0000_2000);
    repeat (4) step(1'b1, 1'b0, 32'h0);

    // Redirect with a slow response in flight: DRAIN, stale word never delivered.
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b1, 1'b0, 32'h0);
      if (pend_valid && pend_left == 3) found = 1'b1;
    end
    check("drain_setup", 32'(found), 32'd1);
    step(1'b1, 1'b1, 32'h0000_1003);
    check("drain_state", 32'(dut.state_q), 32'(DRAIN));
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (instr_valid) begin
        got = 1'b1;
        check("drain_first_pc", pc_out, 32'h0000_1000);
      end else begin
        step(1'b1, 1'b0, 32'h0);
      end
    end
    check("drain_valid_seen", 32'(got), 32'd1);
    repeat (8) step(1'b1, 1'b0, 32'h0);

    // Asynchronous reset with the buffer full, then refetch from RESET_PC.
    lat = 1;
    repeat (3) step(1'b1, 1'b0, 32'h0);
    repeat (4) step(1'b0, 1'b0, 32'h0);
    check("full_before_reset", 32'(dut.u_buffer.count_q), 32'd2);
    #2;
    rst_n = 1'b0;
    imem_rvalid = 1'b1;
    #1;
    check("arst_valid", 32'(instr_valid), 32'd0);
    check("arst_instr", instr_out, NOP_INSTR_DEFAULT);
    check("arst_pc", pc_out, 32'h0);
    check("arst_addr", imem_addr, RESET_PC_DEFAULT);
    check("arst_req", 32'(imem_req), 32'd0);
    pend_valid = 1'b0;
    exp_q.delete();
    exp_pc = RESET_PC_DEFAULT;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pend_valid = 1'b1;
    pend_left = 1;
    pend_addr = 32'h0000_0040;
    step(1'b1, 1'b0, 32'h0);
    check("reboot_noreq", 32'(obs_req), 32'd0);
    step(1'b1, 1'b0, 32'h0);
    check("reboot_req", 32'(obs_req), 32'd1);
    check("reboot_addr", obs_addr, RESET_PC_DEFAULT);
    repeat (6) step(1'b1, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end that sits directly upstream of the decode stage. It owns the program counter and issues word requests to instruction memory. Fetched instruction/PC pairs go into a 2-entry buffer, and that buffer is presented to decode with a valid/ready handshake. Decode can stall without losing fetched words, and a redirect (branch/jump) flushes all speculative state.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset; bits [1:0] must be 0.
- `NOP_INSTR`, default 32'h0000_0000: value driven on `instr_out` while `instr_valid` is 0.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: one clock; reset is asynchronous and active-low.
- `imem_req` output 1: fetch request, valid for one cycle per word.
- `imem_addr` output 32: word address; always equals the internal PC register.
- `imem_rvalid` input 1: response strobe; arrives ≥1 cycle after its `imem_req`.
- `imem_rdata` input 32: instruction word, qualified by `imem_rvalid`.
- `redirect_valid` input 1: one-cycle request to restart fetch at `redirect_pc`.
- `redirect_pc` input 32: target address; bits [1:0] are ignored and treated as 0.
- `id_ready` input 1: decode accepts `instr_out`/`pc_out` this cycle.
- `instr_valid` output 1: buffer head is valid.
- `instr_out` output 32: buffer head instruction, or `NOP_INSTR` when the buffer is empty.
- `pc_out` output 32: buffer head PC, or 0 when the buffer is empty.

## Operation
- **States:** BOOT, RUN, DRAIN.
  - Reset enters BOOT.
  - BOOT goes to RUN unconditionally after one cycle.
  - No request is issued in BOOT.
- **Outstanding requests:** at most one. The `outstanding` flag sets on `imem_req` and clears on `imem_rvalid`. A new request may be issued in the same cycle the previous response returns.
- **Response handling:** in RUN, an `imem_rvalid` response is written to the buffer tail with its issuing PC, which is held in a `req_pc` register.
- **Pop rule:** pop = `instr_valid` && `id_ready` && !`redirect_valid`.
- **Issue rule (RUN):** issue when !`redirect_valid` && (!`outstanding` || `imem_rvalid`) && (count + `imem_rvalid` − pop) < 2.
  - `imem_req` is combinational from `id_ready`, `imem_rvalid` and `redirect_valid`.
- **PC update on issue:** `req_pc` ← PC; PC ← PC + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
- **Redirect, in any state except BOOT:**
  - Buffer cleared at the clock edge.
  - PC ← {`redirect_pc`[31:2], 2'b00}.
  - No request issued that cycle.
  - Any `imem_rvalid` in that cycle is discarded.
  - Next state is DRAIN if `outstanding` && !`imem_rvalid`, otherwise RUN.
- **DRAIN:**
  - The first `imem_rvalid` is discarded.
  - In that same cycle, a request for the new PC may be issued under the RUN issue rule, and the state goes to RUN.
  - A redirect in DRAIN updates the PC and stays in DRAIN.
- **Buffer:** 2-entry FIFO.
  - Simultaneous push and pop while full is legal. It cannot occur under the issue rule, but the FIFO must still handle it.
  - Push while full and not popping is a protocol error; the write is dropped.
- **Reset values:**
  - State = BOOT, PC = `RESET_PC`, buffer empty, `outstanding` = 0.
  - `imem_req` = 0, `imem_addr` = `RESET_PC`, `instr_valid` = 0, `instr_out` = `NOP_INSTR`, `pc_out` = 0.
- **Reset mid-operation:** asserting reset clears everything above immediately. A response that arrives while `rst_n` is low or in BOOT is ignored.

## Timing
- Cycle 0 is the first rising edge with `rst_n` high: BOOT → RUN.
- Cycle 1: `imem_req` = 1, `imem_addr` = `RESET_PC`.
- With 1-cycle memory, `imem_rvalid` arrives in cycle 2 and `instr_valid` = 1 in cycle 3. Fetch-to-decode latency is therefore 2 cycles from the request.
- Steady state with `id_ready` held at 1 and 1-cycle memory: one instruction per cycle, consecutive PCs.
- On an `id_ready` stall, the buffer fills to 2 and `imem_req` drops. `instr_out`/`pc_out` hold stable while `instr_valid` && !`id_ready`.
- After a redirect in cycle t with no outstanding request: request in t+1, `instr_valid` in t+3.
- All outputs except `imem_req` are register outputs.

## Structure
- Package `fetch_pkg` holds:
  - the state enum `fetch_state_t` (BOOT/RUN/DRAIN);
  - the constants `NOP_INSTR_DEFAULT`, `RESET_PC_DEFAULT` and `PC_STEP` = 4;
  - the `fetch_entry_t` struct {pc, instr}.
- The 2-entry FIFO is a sub-module named `fetch_buffer`, with ports push/pop/flush/full/empty/count/head. It is separately testable.

## Test plan
- **Reset, then free-run with 1-cycle memory returning addr ^ 32'hA5A5_0000:** first `instr_valid` in cycle 3 with `pc_out` = 0; PCs 0, 4, 8, … thereafter, one per cycle.
- **`id_ready` low for 5 cycles starting when head PC = 8:** `imem_req` drops once count = 2; `pc_out` holds 8; after release, PCs 8, C, 10 follow with no gap and no duplicate.
- **Redirect to 32'h0000_1003 while a response is outstanding and memory is delayed 3 cycles:** DRAIN entered; stale word never reaches `instr_valid`; next valid `pc_out` = 32'h0000_1000.
- **Redirect and `imem_rvalid` in the same cycle:** that response is dropped; state RUN; request for the target issued the next cycle.
- **PC wrap:** `RESET_PC` = 32'hFFFF_FFF8 yields PCs FFFF_FFF8, FFFF_FFFC, 0000_0000.
- **`rst_n` pulsed low mid-stream with the buffer full:** outputs return to reset values asynchronously; the refetch starts at `RESET_PC`.
